// File: rtl/regfile_dump_reader_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader_if
//   Bundles the control, register-file read port and dump stream signals used
//   by regfile_dump_reader.
//
//   Signals:
//     start        begin a dump (sampled only while idle)
//     abort        synchronous cancel of a dump in progress
//     busy         high while a dump is in progress; steers the shared read port
//     done         one-cycle pulse after the final beat is accepted
//     rf_read_add  register file read address
//     rf_read_data combinational register file read data for rf_read_add
//     dump_valid   beat valid
//     dump_ready   sink accepts the current beat
//     dump_index   register index carried by the current beat
//     dump_data    register value carried by the current beat
//
//   Modports:
//     master  the dump reader
//     slave   the environment: controller, register file and trace sink
// -----------------------------------------------------------------------------
interface regfile_dump_reader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_read_add;
    logic [DATA_W-1:0] rf_read_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;

    modport master (
        input  start,
        input  abort,
        input  rf_read_data,
        input  dump_ready,
        output busy,
        output done,
        output rf_read_add,
        output dump_valid,
        output dump_index,
        output dump_data
    );

    modport slave (
        output start,
        output abort,
        output rf_read_data,
        output dump_ready,
        input  busy,
        input  done,
        input  rf_read_add,
        input  dump_valid,
        input  dump_index,
        input  dump_data
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//   Synthesizable dump path for the register file. On a start pulse it walks
//   the shared read port from FIRST_REG up to NUM_REGS-1 and streams each
//   (index, value) pair to a trace sink over a valid/ready handshake.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    regfile_dump_reader_if.master (start/abort, busy/done, register
//            file read port, dump stream)
//
//   Optional feature:
//     REGDUMP_SKIP_ZERO_EN  when defined, registers reading as zero produce no
//                           beat; each skipped register costs one cycle.
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIRST_REG = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_dump_reader_if.master  bus
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] w_index_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_skip;
    logic              w_last;

    assign w_last = (r_cnt == LAST_IDX);

`ifdef REGDUMP_SKIP_ZERO_EN
    assign w_skip = (bus.rf_read_data == '0);
`else
    assign w_skip = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= FIRST_IDX;
            r_valid <= 1'b0;
            r_index <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_index <= w_index_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_index_nxt = r_index;
        w_data_nxt  = r_data;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = FIRST_IDX;
                end
            end
            S_FETCH: begin
                if (w_skip) begin
                    // No beat for this register; move straight to the next one.
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_W'(1);
                    end
                end else begin
                    w_valid_nxt = 1'b1;
                    w_index_nxt = r_cnt;
                    w_data_nxt  = bus.rf_read_data;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.dump_ready) begin
                    w_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        // Abort overrides any accept or transition decided above.
        if (r_state != S_IDLE && bus.abort) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    // Address follows the counter, which stays put through SEND and DONE.
    assign bus.rf_read_add = (r_state == S_IDLE) ? '0 : r_cnt;
    assign bus.dump_valid  = r_valid;
    assign bus.dump_index  = r_index;
    assign bus.dump_data   = r_data;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    localparam int NREGS = 32;
`ifdef REGDUMP_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [31:0] regs [NREGS];

    beat_t exp_q[$];
    int    total;
    int    bad;
    int    done_seen;
    int    beats_seen;
    int    exp_done;
    int    ready_mode;
    int    stall_idx;
    int    cyc;

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dump_reader #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .DATA_W   (32),
        .FIRST_REG(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    assign bus.rf_read_data = regs[bus.rf_read_add];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready driver: 0 = always ready, 1 = ready one cycle in three,
    // 2 = ready except while presenting stall_idx.
    initial begin
        bus.dump_ready = 1'b0;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       bus.dump_ready = 1'b1;
                1:       bus.dump_ready = (cyc % 3 == 0);
                default: bus.dump_ready = !(bus.dump_valid && bus.dump_index == 5'(stall_idx));
            endcase
        end
    end

    // Monitor: compares accepted beats to the scoreboard, checks hold stability.
    initial begin
        logic        hold_pending;
        logic [4:0]  hold_idx;
        logic [31:0] hold_data;
        beat_t       e;
        hold_pending = 1'b0;
        hold_idx = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_pending = 1'b0;
            end else begin
                if (bus.done) begin
                    done_seen++;
                    check("done_all_beats_sent", exp_q.size(), 0);
                end
                if (bus.dump_valid) begin
                    if (hold_pending) begin
                        check("hold_index_stable", bus.dump_index, hold_idx);
                        check("hold_data_stable", bus.dump_data, hold_data);
                    end
                    if (bus.dump_ready) begin
                        hold_pending = 1'b0;
                        beats_seen++;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL beat_unexpected: got idx %0d data %0h expected no beat",
                                     bus.dump_index, bus.dump_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_index", bus.dump_index, e.idx);
                            check("beat_data", bus.dump_data, e.data);
                        end
                    end else begin
                        hold_pending = 1'b1;
                        hold_idx = bus.dump_index;
                        hold_data = bus.dump_data;
                    end
                end else begin
                    hold_pending = 1'b0;
                end
            end
        end
    end

    task automatic push_dump(output int n);
        beat_t b;
        n = 0;
        for (int i = 0; i < NREGS; i++) begin
            if (!SKIP_ZERO || regs[i] != 32'h0) begin
                b.idx = 5'(i);
                b.data = regs[i];
                exp_q.push_back(b);
                n++;
            end
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: got busy after %0d cycles expected idle", name, limit);
        end
        tick();
    endtask

    task automatic wait_send(input int idx, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (bus.dump_valid && bus.dump_index == 5'(idx)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_send_%0d: got no beat in %0d cycles expected beat", idx, limit);
        end
    endtask

    task automatic full_dump(input string name);
        int n;
        int b0;
        b0 = beats_seen;
        push_dump(n);
        pulse_start();
        wait_idle(name, 400);
        exp_done++;
        check({name, "_beats"}, beats_seen - b0, n);
        check({name, "_done_count"}, done_seen, exp_done);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic load_file(input bit all_zero);
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;
        if (!all_zero) begin
            regs[1] = 32'h0000_00A5;
            regs[2] = 32'hFFFF_FF5A;
        end
    endtask

    initial begin
        bit ok;
        total = 0;
        bad = 0;
        done_seen = 0;
        beats_seen = 0;
        exp_done = 0;
        ready_mode = 0;
        stall_idx = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        load_file(1'b0);

        // Reset state
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.dump_valid, 0);
        check("rst_rd_add", bus.rf_read_add, 0);
        check("rst_index", bus.dump_index, 0);
        check("rst_data", bus.dump_data, 0);
        reset = 1'b1;
        repeat (2) tick();

        // 1: full dump, sink always ready
        ready_mode = 0;
        full_dump("t1");

        // 2: sink ready one cycle in three
        ready_mode = 1;
        full_dump("t2");
        ready_mode = 0;

        // 3: start mid-dump and during DONE is ignored
        begin
            int n;
            push_dump(n);
            pulse_start();
            repeat (10) tick();
            pulse_start();
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (bus.done) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check("t3_reached_done", ok, 1);
            pulse_start();
            repeat (5) tick();
            exp_done++;
            check("t3_start_in_done_ignored", bus.busy, 0);
            check("t3_done_count", done_seen, exp_done);
            check("t3_queue_empty", exp_q.size(), 0);
        end

        // 4: abort while index 7 is waiting
        begin
            int n;
            push_dump(n);
            ready_mode = 2;
            stall_idx = 7;
            pulse_start();
            wait_send(7, 100, ok);
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            check("t4_valid_after_abort", bus.dump_valid, 0);
            check("t4_busy_after_abort", bus.busy, 0);
            check("t4_done_after_abort", bus.done, 0);
            exp_q.delete();
            repeat (4) tick();
            check("t4_no_done", done_seen, exp_done);
            ready_mode = 0;
            full_dump("t4_restart");
        end

        // 5: reset asserted while index 12 is waiting
        begin
            int n;
            push_dump(n);
            ready_mode = 2;
            stall_idx = 12;
            pulse_start();
            wait_send(12, 100, ok);
            reset = 1'b0;
            #1;
            check("t5_busy", bus.busy, 0);
            check("t5_done", bus.done, 0);
            check("t5_valid", bus.dump_valid, 0);
            check("t5_rd_add", bus.rf_read_add, 0);
            check("t5_index", bus.dump_index, 0);
            check("t5_data", bus.dump_data, 0);
            exp_q.delete();
            repeat (3) tick();
            reset = 1'b1;
            ready_mode = 0;
            repeat (2) tick();
            check("t5_no_done", done_seen, exp_done);
            full_dump("t5_restart");
        end

        // 6: all-zero file (no beats when zero skipping is enabled)
        load_file(1'b1);
        full_dump("t6_zero_file");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
